// File: rtl/traffic_junction.sv
// Two-road junction controller: main/side signal cycle with optional pedestrian
// phase and a night-time flashing-yellow mode. Lamps decode from registered state only.
module traffic_junction #(
   parameter int CNT_W     = 8,
   parameter int GREEN_M_T = 8,
   parameter int GREEN_S_T = 5,
   parameter int YELLOW_T  = 2,
   parameter int REDYLW_T  = 2,
   parameter int ALLRED_T  = 1,
   parameter int WALK_T    = 4,
   parameter int FLASH_T   = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic ped_req,
   input  logic night,
   output logic m_red,
   output logic m_yellow,
   output logic m_green,
   output logic s_red,
   output logic s_yellow,
   output logic s_green,
   output logic walk
);

   typedef enum logic [3:0] {
      M_RY, M_GRN, M_YLW, AR_A, S_RY, S_GRN, S_YLW, AR_B, PED, FLASH
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_last;
   logic             w_done;
   logic             w_enterPed;
   logic             r_pedPend;
   logic             r_pedFromA;
   logic             r_flashPh;

   // Final count value of the current state; in FLASH it marks a half-period.
   always_comb begin
      w_last = CNT_W'(ALLRED_T - 1);
      case (r_state)
         M_RY, S_RY:   w_last = CNT_W'(REDYLW_T - 1);
         M_GRN:        w_last = CNT_W'(GREEN_M_T - 1);
         S_GRN:        w_last = CNT_W'(GREEN_S_T - 1);
         M_YLW, S_YLW: w_last = CNT_W'(YELLOW_T - 1);
         PED:          w_last = CNT_W'(WALK_T - 1);
         FLASH:        w_last = CNT_W'(FLASH_T - 1);
         default:      w_last = CNT_W'(ALLRED_T - 1);
      endcase
   end

   assign w_done = (r_cnt == w_last);

   // Night and pedestrian requests are only honoured at all-red expiry, so a
   // running green or yellow is never cut short.
   always_comb begin
      w_next = r_state;
      case (r_state)
         M_RY:  if (w_done) w_next = M_GRN;
         M_GRN: if (w_done) w_next = M_YLW;
         M_YLW: if (w_done) w_next = AR_A;
         AR_A: begin
            if (w_done) begin
               if (night)          w_next = FLASH;
               else if (r_pedPend) w_next = PED;
               else                w_next = S_RY;
            end
         end
         S_RY:  if (w_done) w_next = S_GRN;
         S_GRN: if (w_done) w_next = S_YLW;
         S_YLW: if (w_done) w_next = AR_B;
         AR_B: begin
            if (w_done) begin
               if (night)          w_next = FLASH;
               else if (r_pedPend) w_next = PED;
               else                w_next = M_RY;
            end
         end
         PED:   if (w_done) w_next = r_pedFromA ? S_RY : M_RY;
         FLASH: if (!night) w_next = AR_B;
         default: w_next = AR_B;
      endcase
   end

   assign w_enterPed = (w_next == PED) && (r_state != PED);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= AR_B;
         r_cnt      <= '0;
         r_pedPend  <= 1'b0;
         r_pedFromA <= 1'b0;
         r_flashPh  <= 1'b1;
      end else begin
         r_state <= w_next;
         if ((w_next != r_state) || w_done)
            r_cnt <= '0;
         else
            r_cnt <= r_cnt + CNT_W'(1);
         // A request arriving on the PED entry edge belongs to the next round.
         if (w_enterPed) begin
            r_pedPend  <= ped_req;
            r_pedFromA <= (r_state == AR_A);
         end else begin
            r_pedPend  <= r_pedPend | ped_req;
         end
         if ((w_next == FLASH) && (r_state != FLASH))
            r_flashPh <= 1'b1;
         else if ((r_state == FLASH) && w_done)
            r_flashPh <= ~r_flashPh;
      end
   end

   always_comb begin
      m_red    = 1'b1;
      m_yellow = 1'b0;
      m_green  = 1'b0;
      s_red    = 1'b1;
      s_yellow = 1'b0;
      s_green  = 1'b0;
      walk     = 1'b0;
      case (r_state)
         M_RY:  m_yellow = 1'b1;
         M_GRN: begin m_red = 1'b0; m_green  = 1'b1; end
         M_YLW: begin m_red = 1'b0; m_yellow = 1'b1; end
         S_RY:  s_yellow = 1'b1;
         S_GRN: begin s_red = 1'b0; s_green  = 1'b1; end
         S_YLW: begin s_red = 1'b0; s_yellow = 1'b1; end
         PED:   walk = 1'b1;
         FLASH: begin
            m_red    = 1'b0;
            s_red    = 1'b0;
            m_yellow = r_flashPh;
            s_yellow = r_flashPh;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_traffic_junction.sv
// Bench for traffic_junction: nominal timing table, hand-written pedestrian/night/reset
// sequences, and a randomized run against a countdown-based schedule model.
module tb_traffic_junction;

   localparam int GREEN_M_T = 8;
   localparam int GREEN_S_T = 5;
   localparam int YELLOW_T  = 2;
   localparam int REDYLW_T  = 2;
   localparam int ALLRED_T  = 1;
   localparam int WALK_T    = 4;
   localparam int FLASH_T   = 3;

   // Lamp vectors {m_red, m_yellow, m_green, s_red, s_yellow, s_green, walk}
   localparam logic [6:0] L_MRY  = 7'b110_100_0;
   localparam logic [6:0] L_MGRN = 7'b001_100_0;
   localparam logic [6:0] L_MYLW = 7'b010_100_0;
   localparam logic [6:0] L_AR   = 7'b100_100_0;
   localparam logic [6:0] L_SRY  = 7'b100_110_0;
   localparam logic [6:0] L_SGRN = 7'b100_001_0;
   localparam logic [6:0] L_SYLW = 7'b100_010_0;
   localparam logic [6:0] L_PED  = 7'b100_100_1;
   localparam logic [6:0] L_FL1  = 7'b010_010_0;
   localparam logic [6:0] L_FL0  = 7'b000_000_0;

   logic clk = 1'b0;
   logic rst;
   logic ped_req;
   logic night;
   logic m_red, m_yellow, m_green, s_red, s_yellow, s_green, walk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   traffic_junction dut (
      .clk      (clk),
      .rst      (rst),
      .ped_req  (ped_req),
      .night    (night),
      .m_red    (m_red),
      .m_yellow (m_yellow),
      .m_green  (m_green),
      .s_red    (s_red),
      .s_yellow (s_yellow),
      .s_green  (s_green),
      .walk     (walk)
   );

   always #5 clk = ~clk;

   // Reference model: phase with remaining-cycle countdown and time spent flashing.
   typedef enum int {P_MRY, P_MGRN, P_MYLW, P_ARA, P_SRY, P_SGRN, P_SYLW, P_ARB, P_PED, P_FLASH} phase_e;

   phase_e mPh;
   int     mLeft;
   int     mFlashAge;
   bit     mPend;
   bit     mFromA;

   function automatic int durOf(phase_e p);
      case (p)
         P_MRY, P_SRY:   return REDYLW_T;
         P_MGRN:         return GREEN_M_T;
         P_SGRN:         return GREEN_S_T;
         P_MYLW, P_SYLW: return YELLOW_T;
         P_PED:          return WALK_T;
         default:        return ALLRED_T;
      endcase
   endfunction

   function automatic logic [6:0] modelLamps();
      case (mPh)
         P_MRY:   return L_MRY;
         P_MGRN:  return L_MGRN;
         P_MYLW:  return L_MYLW;
         P_SRY:   return L_SRY;
         P_SGRN:  return L_SGRN;
         P_SYLW:  return L_SYLW;
         P_PED:   return L_PED;
         P_FLASH: return (((mFlashAge / FLASH_T) % 2) == 0) ? L_FL1 : L_FL0;
         default: return L_AR;
      endcase
   endfunction

   task automatic goPhase(input phase_e p);
      mPh       = p;
      mLeft     = durOf(p);
      mFlashAge = 0;
   endtask

   task automatic modelReset();
      goPhase(P_ARB);
      mPend  = 1'b0;
      mFromA = 1'b0;
   endtask

   task automatic modelStep(input bit p, input bit n);
      bit enterPed;
      enterPed = 1'b0;
      if (mPh == P_FLASH) begin
         if (!n) goPhase(P_ARB);
         else    mFlashAge++;
      end else begin
         mLeft--;
         if (mLeft == 0) begin
            case (mPh)
               P_MRY:  goPhase(P_MGRN);
               P_MGRN: goPhase(P_MYLW);
               P_MYLW: goPhase(P_ARA);
               P_SRY:  goPhase(P_SGRN);
               P_SGRN: goPhase(P_SYLW);
               P_SYLW: goPhase(P_ARB);
               P_PED:  goPhase(mFromA ? P_SRY : P_MRY);
               default: begin
                  if (n) begin
                     goPhase(P_FLASH);
                  end else if (mPend) begin
                     mFromA   = (mPh == P_ARA);
                     enterPed = 1'b1;
                     goPhase(P_PED);
                  end else begin
                     goPhase((mPh == P_ARA) ? P_SRY : P_MRY);
                  end
               end
            endcase
         end
      end
      mPend = enterPed ? p : (mPend | p);
   endtask

   function automatic logic [6:0] lampsNow();
      return {m_red, m_yellow, m_green, s_red, s_yellow, s_green, walk};
   endfunction

   task automatic checkOutput(input string name, input logic [6:0] exp);
      tests++;
      if (lampsNow() !== exp) begin
         fails++;
         $display("[TB] FAIL %s cycle %0d: lamps %b, expected %b", name, cyc, lampsNow(), exp);
      end
   endtask

   // Both roads never show green/yellow together, and some red is lit, unless flashing.
   task automatic checkSafety();
      bit flashLike;
      bit ok;
      flashLike = !m_red && !s_red && !m_green && !s_green && !walk;
      ok = flashLike || ((m_red || s_red) && !((m_green || m_yellow) && (s_green || s_yellow)));
      tests++;
      if (!ok) begin
         fails++;
         $display("[TB] FAIL safety cycle %0d: lamps %b, expected a red lit and no conflicting go", cyc, lampsNow());
      end
   endtask

   task automatic applyStimulus(input bit p, input bit n);
      ped_req = p;
      night   = n;
      @(posedge clk);
      modelStep(p, n);
      @(negedge clk);
      ped_req = 1'b0;
      cyc++;
      checkSafety();
      checkOutput("model", modelLamps());
   endtask

   task automatic resetDut();
      ped_req = 1'b0;
      night   = 1'b0;
      rst     = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("reset", L_AR);
      modelReset();
      rst = 1'b1;
      cyc = 1;
   endtask

   typedef struct {
      bit         ped;
      bit         night;
      logic [6:0] exp;
   } vec_t;

   vec_t tbl[25];

   task automatic runTable();
      for (int i = 0; i < 25; i++) begin
         checkOutput($sformatf("nominal_c%0d", i + 1), tbl[i].exp);
         applyStimulus(tbl[i].ped, tbl[i].night);
      end
   endtask

   initial begin
      bit nightLvl;

      for (int k = 1; k <= 25; k++) begin
         tbl[k-1].ped   = 1'b0;
         tbl[k-1].night = 1'b0;
         if (k == 1)       tbl[k-1].exp = L_AR;
         else if (k <= 3)  tbl[k-1].exp = L_MRY;
         else if (k <= 11) tbl[k-1].exp = L_MGRN;
         else if (k <= 13) tbl[k-1].exp = L_MYLW;
         else if (k == 14) tbl[k-1].exp = L_AR;
         else if (k <= 16) tbl[k-1].exp = L_SRY;
         else if (k <= 21) tbl[k-1].exp = L_SGRN;
         else if (k <= 23) tbl[k-1].exp = L_SYLW;
         else if (k == 24) tbl[k-1].exp = L_AR;
         else              tbl[k-1].exp = L_MRY;
      end

      // Nominal cycle with no inputs
      resetDut();
      runTable();

      // Pedestrian pulse at cycle 5
      resetDut();
      for (int k = 1; k <= 42; k++) begin
         case (k)
            14:             checkOutput("ped_ar_a", L_AR);
            15, 16, 17, 18: checkOutput("ped_walk", L_PED);
            19:             checkOutput("ped_then_sry", L_SRY);
            28:             checkOutput("ped_ar_b", L_AR);
            29:             checkOutput("ped_mry", L_MRY);
            42:             checkOutput("ped_once", L_SRY);
            default: ;
         endcase
         applyStimulus(k == 5, 1'b0);
      end

      // Night from cycle 5 until sampled low at cycle 22
      resetDut();
      for (int k = 1; k <= 26; k++) begin
         case (k)
            4, 11:      checkOutput("night_green_kept", L_MGRN);
            12, 13:     checkOutput("night_yellow_kept", L_MYLW);
            14:         checkOutput("night_ar_a", L_AR);
            15, 16, 17: checkOutput("flash_on", L_FL1);
            18, 19, 20: checkOutput("flash_off", L_FL0);
            21, 22:     checkOutput("flash_on2", L_FL1);
            23:         checkOutput("night_exit_arb", L_AR);
            24:         checkOutput("night_exit_mry", L_MRY);
            26:         checkOutput("night_exit_mgrn", L_MGRN);
            default: ;
         endcase
         applyStimulus(1'b0, (k >= 5) && (k < 22));
      end

      // Night and pedestrian pending together
      resetDut();
      for (int k = 1; k <= 28; k++) begin
         case (k)
            14:             checkOutput("both_ar_a", L_AR);
            15:             checkOutput("both_flash_first", L_FL1);
            20:             checkOutput("both_flash_off", L_FL0);
            21:             checkOutput("both_arb", L_AR);
            22, 23, 24, 25: checkOutput("both_ped", L_PED);
            26, 27:         checkOutput("both_mry", L_MRY);
            28:             checkOutput("both_mgrn", L_MGRN);
            default: ;
         endcase
         applyStimulus(k == 5, (k >= 5) && (k < 20));
      end

      // Asynchronous reset between edges while main road is green
      resetDut();
      for (int k = 1; k <= 6; k++) applyStimulus(1'b0, 1'b0);
      checkOutput("pre_reset_mgrn", L_MGRN);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("async_reset", L_AR);
      modelReset();
      @(negedge clk);
      checkOutput("reset_hold", L_AR);
      rst = 1'b1;
      cyc = 1;
      runTable();

      // Randomized run against the model
      resetDut();
      nightLvl = 1'b0;
      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(0, 39) == 0) nightLvl = ~nightLvl;
         applyStimulus($urandom_range(0, 9) == 0, nightLvl);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/traffic_junction.md
TRAFFIC_JUNCTION -- requirements
Module: traffic_junction

Interface
REQ-001 SHALL have parameter CNT_W, default 8, phase-counter width; it SHALL hold every *_T value minus 1.
REQ-002 SHALL have parameters GREEN_M_T (8) and GREEN_S_T (5), giving main and side green duration in cycles.
REQ-003 SHALL have parameters YELLOW_T (2) for yellow duration, REDYLW_T (2) for red+yellow duration, and ALLRED_T (1) for all-red clearance, all in cycles.
REQ-004 SHALL have parameter WALK_T (4), pedestrian walk cycles, and parameter FLASH_T (3), night-flash half-period in cycles; every *_T value SHALL be >= 1.
REQ-005 clk  input  1  single clock, rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-007 ped_req  input  1  pedestrian request; a 1-cycle pulse is sufficient.
REQ-008 night  input  1  level; requests flashing-yellow mode.
REQ-009 m_red, m_yellow, m_green  output  1 each  main-road lamps.
REQ-010 s_red, s_yellow, s_green  output  1 each  side-road lamps.
REQ-011 walk  output  1  pedestrian walk lamp.

Function
REQ-012 SHALL implement a Moore FSM with states M_RY, M_GRN, M_YLW, AR_A, S_RY, S_GRN, S_YLW, AR_B, PED, FLASH; outputs SHALL decode only from registered state and flash phase.
REQ-013 Each timed state SHALL last exactly its parameter in cycles (M_RY/S_RY=REDYLW_T, M_GRN=GREEN_M_T, S_GRN=GREEN_S_T, *_YLW=YELLOW_T, AR_*=ALLRED_T, PED=WALK_T); the counter SHALL clear to 0 on every state change and advance at count==T-1.
REQ-014 Normal sequence SHALL be M_RY -> M_GRN -> M_YLW -> AR_A -> S_RY -> S_GRN -> S_YLW -> AR_B -> M_RY.
REQ-015 Lamps: in M_RY, m_red=m_yellow=1; in M_GRN, m_green=1; in M_YLW, m_yellow=1; otherwise m_red=1. Side lamps SHALL mirror this for the S_* states. walk=1 only in PED.
REQ-016 The two roads SHALL never show green or yellow simultaneously outside FLASH; at least one red SHALL be lit in every non-FLASH state.
REQ-017 ped_req SHALL set a sticky ped_pend flag on the edge where it is sampled high; entry to PED SHALL clear ped_pend, and a request sampled in the same cycle as entry to PED SHALL be retained.
REQ-018 At the end of AR_A or AR_B with ped_pend=1 and night=0, the FSM SHALL enter PED; on PED expiry it SHALL continue to the state AR would have gone to (S_RY after AR_A, M_RY after AR_B).
REQ-019 At the end of AR_A or AR_B with night=1, the FSM SHALL enter FLASH; night has priority over ped_pend, and ped_pend SHALL be kept.
REQ-020 In FLASH, all red/green lamps SHALL be 0 and m_yellow=s_yellow=flash phase; the phase SHALL start at 1 and toggle every FLASH_T cycles.
REQ-021 In FLASH with night sampled 0, the FSM SHALL go to AR_B next cycle; ped_pend is then served at AR_B expiry.
REQ-022 night rising mid-cycle SHALL NOT shorten any green or yellow; it takes effect only at the next AR expiry.

Reset
REQ-023 rst=0 SHALL immediately and asynchronously force state=AR_B, counter=0, ped_pend=0, and flash phase=1.
REQ-024 Outputs during reset SHALL be m_red=1 and s_red=1, with all other lamps and walk at 0; this holds regardless of the state when reset was asserted.
REQ-025 After rst rises, the first rising edge SHALL count as cycle 1 of AR_B.

Verification (default parameters; cycle 1 = first edge after rst release)
REQ-026 No inputs -> AR_B at cycle 1, M_RY at cycles 2-3, M_GRN at 4-11, M_YLW at 12-13, AR_A at 14, S_RY at 15-16, S_GRN at 17-21, S_YLW at 22-23, AR_B at 24, M_RY at 25.
REQ-027 ped_req pulse at cycle 5 -> PED (walk=1, both reds) at cycles 15-18, then S_RY at 19; no second PED unless ped_req recurs.
REQ-028 night=1 from cycle 5 -> green unchanged until 11, FLASH from 15, yellows 1,1,1,0,0,0,...; night=0 while in FLASH -> AR_B next cycle, then M_RY.
REQ-029 night=1 and ped_req both pending at AR_A -> FLASH first; after night=0, AR_B then PED then M_RY.
REQ-030 rst=0 asserted mid-M_GRN and asynchronously between edges -> m_green falls and m_red/s_red rise without waiting for a clock; after release, REQ-026 timing repeats.
REQ-031 Over every scenario, a checker SHALL assert REQ-016 on every cycle.
